step_tick_ctrl: RTL and testbench
=================================

Name: step_tick_ctrl

Overview:
Upstream control stage for the LED state-sequencer. It replaces the free-running divided clock with a single-cycle step enable (step_en), so the downstream sequencer registers advance on clk gated by step_en. Two debounced push-buttons select run/pause and single-step. The divide period is runtime-loadable.

Parameters:
DIV_WIDTH, 32, width of divide counter and period register
DIV_DEFAULT, 250000000, period register value after reset; step period = DIV_DEFAULT+1 cycles
DEB_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (>=2)

Ports:
clk  in  1  system clock; the only clock
rst_n  in  1  asynchronous, active-low reset
btn_mode_raw  in  1  asynchronous mode button, active-high, bouncing
btn_step_raw  in  1  asynchronous step button, active-high, bouncing
div_load  in  1  one-cycle strobe: load div_value into period register
div_value  in  DIV_WIDTH  new period minus one
step_en  out  1  registered one-cycle step pulse to sequencer
phase  out  1  toggles on every step_en (half-rate square wave)
run_led  out  1  1 in RUN, 0 otherwise
mode  out  2  current FSM state code

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (async on rst_n low, released synchronously):
  - step_en=0, phase=0, mode=RUN, run_led=1.
  - div_reg=DIV_DEFAULT, cnt=0.
  - Synchronizers, debounce counters and debounced levels all 0.
- Input conditioning (per button):
  - 2-FF synchronizer, then debounce.
  - Debounce counter increments while sync output != deb_level, and clears to 0 whenever they are equal.
  - When the count reaches DEB_CYCLES-1 with inputs still differing, deb_level flips on the next edge and the counter clears.
  - Press pulse = registered rising edge of deb_level.
  - A raw rise stable from edge t gives deb_level high at t+2+DEB_CYCLES, the press pulse at t+3+DEB_CYCLES, and its effect (mode / step_en) registered at t+4+DEB_CYCLES.
  - Glitches shorter than DEB_CYCLES are ignored.
- FSM states (codes): PAUSE=2'b00, RUN=2'b01, STEP=2'b10.
  - RUN + mode press -> PAUSE.
  - PAUSE + mode press -> RUN, with cnt cleared to 0.
  - PAUSE + step press -> STEP.
  - STEP -> PAUSE unconditionally after one cycle; step_en=1 on the cycle after entering STEP.
  - Step press in RUN is ignored.
  - Mode and step press in the same cycle: mode wins, step dropped.
- Divider:
  - In RUN: if cnt==div_reg then cnt<=0 and step_en<=1; else cnt<=cnt+1 and step_en<=0.
  - In PAUSE/STEP: cnt holds, and step_en comes only from the STEP rule.
  - Period is div_reg+1 cycles; div_reg=0 gives step_en high every cycle.
- div_load:
  - div_reg<=div_value and cnt<=0 on the next edge, in any state.
  - If it coincides with terminal count, the load wins and no step_en is issued that cycle.
  - div_load coinciding with a RUN-entry clear has the same result (cnt=0).
- phase toggles on the same edge step_en is asserted. run_led = (mode==RUN), registered with mode.
- cnt wrap-around cannot occur since cnt<=div_reg always holds. After a load of a smaller value, cnt is already 0.
- rst_n low mid-count or mid-debounce aborts everything immediately. No step_en is emitted on reset release.

Decomposition:
- Package step_tick_pkg: mode typedef (PAUSE/RUN/STEP codes) and the default DIV/DEB constants.
- Sub-module btn_debounce (synchronizer + debounce counter + rising-edge pulse), instantiated twice.
- FSM and divider live in the top.

Test Plan:
Use DIV_DEFAULT=9, DEB_CYCLES=4 throughout.
1. Release rst_n, buttons idle -> first step_en on the 10th edge after release, then every 10 cycles; phase toggles 0->1->0; mode=01, run_led=1.
2. btn_mode_raw high for 3 cycles then low -> no mode change; held 10 cycles -> mode=00 at edge t+8, run_led=0, no further step_en.
3. In PAUSE, a clean step press -> exactly one step_en at t+8, mode 00->10->00, phase toggles once; cnt unchanged.
4. In RUN, div_load=1 with div_value=3 -> step_en every 4 cycles starting 4 cycles after load; load coinciding with cnt==9 -> no pulse that cycle.
5. Mode and step pressed simultaneously in RUN -> mode=00, zero extra step_en; a second mode press -> RUN, next step_en 10 cycles later.
6. rst_n asserted at cnt=5 between clock edges -> step_en=0, phase=0, mode=01 immediately; after release, period restarts from 0.

Source files
------------

// File: rtl/step_tick_pkg.sv
// Shared definitions for the step-enable control block: FSM state codes and
// default divider/debounce settings.
package step_tick_pkg;

    typedef enum logic [1:0] {
        PAUSE = 2'b00,
        RUN   = 2'b01,
        STEP  = 2'b10
    } mode_t;

    localparam int          DIV_WIDTH_C   = 32;
    localparam int unsigned DIV_DEFAULT_C = 32'd250000000;
    localparam int          DEB_CYCLES_C  = 1000000;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability-counter debounce and registered
// rising-edge pulse for one bouncing push-button.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int            CW       = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic          level_p2;
    logic          level_p3;
    logic [CW-1:0] cnt_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            level_p2 <= 1'b0;
            level_p3 <= 1'b0;
            cnt_p2   <= '0;
            press    <= 1'b0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            // Any return to the accepted level restarts the stability window
            if (sync_p1 == level_p2) begin
                cnt_p2 <= '0;
            end else if (cnt_p2 == CNT_LAST) begin
                cnt_p2   <= '0;
                level_p2 <= sync_p1;
            end else begin
                cnt_p2 <= cnt_p2 + CW'(1);
            end
            level_p3 <= level_p2;
            press    <= level_p2 & ~level_p3;
        end
    end

endmodule

// File: rtl/step_tick_ctrl.sv
// Run/pause/single-step controller producing a one-cycle step enable from a
// runtime-loadable divider, driven by two debounced buttons.
module step_tick_ctrl
    import step_tick_pkg::*;
#(
    parameter int          DIV_WIDTH   = DIV_WIDTH_C,
    parameter int unsigned DIV_DEFAULT = DIV_DEFAULT_C,
    parameter int          DEB_CYCLES  = DEB_CYCLES_C
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_mode_raw,
    input  logic                 btn_step_raw,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_value,
    output logic                 step_en,
    output logic                 phase,
    output logic                 run_led,
    output logic [1:0]           mode
);

    mode_t                state;
    mode_t                state_nx;
    logic                 mode_press;
    logic                 step_press;
    logic [DIV_WIDTH-1:0] div_reg;
    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] cnt_nx;
    logic                 step_nx;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_mode_raw),
        .press   (mode_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_step_raw),
        .press   (step_press)
    );

    // Mode press takes priority over a simultaneous step press
    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (mode_press) state_nx = PAUSE;
            PAUSE:   if (mode_press) state_nx = RUN;
                     else if (step_press) state_nx = STEP;
            STEP:    state_nx = PAUSE;
            default: state_nx = PAUSE;
        endcase
    end

    always_comb begin
        cnt_nx  = cnt;
        step_nx = 1'b0;
        if (state == RUN) begin
            if (cnt == div_reg) begin
                cnt_nx  = '0;
                step_nx = 1'b1;
            end else begin
                cnt_nx = cnt + DIV_WIDTH'(1);
            end
        end else if (state == PAUSE && state_nx == STEP) begin
            step_nx = 1'b1;
        end
        if (state == PAUSE && state_nx == RUN) cnt_nx = '0;
        // A period load restarts the count and suppresses a coinciding terminal pulse
        if (div_load) begin
            cnt_nx = '0;
            if (state == RUN) step_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            cnt     <= '0;
            div_reg <= DIV_WIDTH'(DIV_DEFAULT);
            step_en <= 1'b0;
            phase   <= 1'b0;
            run_led <= 1'b1;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            if (div_load) div_reg <= div_value;
            step_en <= step_nx;
            if (step_nx) phase <= ~phase;
            run_led <= (state_nx == RUN);
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_step_tick_ctrl.sv
// Directed bench for step_tick_ctrl with a short divide period and short
// debounce window; expected pulse schedules are hand-derived.
module tb_step_tick_ctrl;

    logic        clk;
    logic        rst_n;
    logic        btn_mode_raw;
    logic        btn_step_raw;
    logic        div_load;
    logic [31:0] div_value;
    logic        step_en;
    logic        phase;
    logic        run_led;
    logic [1:0]  mode;

    int   n_chk;
    int   n_pass;
    logic phase_exp;

    step_tick_ctrl #(
        .DIV_WIDTH   (32),
        .DIV_DEFAULT (9),
        .DEB_CYCLES  (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_mode_raw (btn_mode_raw),
        .btn_step_raw (btn_step_raw),
        .div_load     (div_load),
        .div_value    (div_value),
        .step_en      (step_en),
        .phase        (phase),
        .run_led      (run_led),
        .mode         (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n edges; a step pulse is expected at edge 'first' and every
    // 'period' edges after (period 0: only at 'first'; first 0: never).
    // Both buttons are released right after edge rel_at.
    task automatic expect_steps(input string tag, input int n, input int first,
                                input int period, input int rel_at);
        logic exp;
        for (int i = 1; i <= n; i++) begin
            tick();
            exp = (first > 0) && (i >= first) &&
                  ((period == 0) ? (i == first) : (((i - first) % period) == 0));
            if (exp) phase_exp = ~phase_exp;
            chk({tag, "_step"}, 32'(step_en), 32'(exp));
            chk({tag, "_phase"}, 32'(phase), 32'(phase_exp));
            if (i == rel_at) begin
                btn_mode_raw = 1'b0;
                btn_step_raw = 1'b0;
            end
        end
    endtask

    task automatic chk_mode(input string tag, input logic [1:0] m);
        chk({tag, "_mode"}, 32'(mode), 32'(m));
        chk({tag, "_led"}, 32'(run_led), 32'(m == 2'b01));
    endtask

    initial begin
        n_chk        = 0;
        n_pass       = 0;
        phase_exp    = 1'b0;
        rst_n        = 1'b0;
        btn_mode_raw = 1'b0;
        btn_step_raw = 1'b0;
        div_load     = 1'b0;
        div_value    = 32'd0;

        // Reset state
        repeat (3) tick();
        chk("rst_step", 32'(step_en), 32'd0);
        chk("rst_phase", 32'(phase), 32'd0);
        chk_mode("rst", 2'b01);
        rst_n = 1'b1;

        // Free run: period 10 from release
        expect_steps("t1", 30, 10, 10, 99);
        chk_mode("t1", 2'b01);

        // Three-cycle glitch ignored (cnt goes 0 -> 8)
        btn_mode_raw = 1'b1;
        expect_steps("t2g", 8, 10, 10, 3);
        chk_mode("t2g", 2'b01);

        // Held mode press -> PAUSE at edge 8, terminal count at edge 2
        btn_mode_raw = 1'b1;
        expect_steps("t2h", 8, 2, 10, 99);
        chk_mode("t2h", 2'b00);
        expect_steps("t2p", 20, 0, 0, 2);
        chk_mode("t2p", 2'b00);

        // Single step from PAUSE
        btn_step_raw = 1'b1;
        expect_steps("t3a", 7, 0, 0, 99);
        expect_steps("t3s", 1, 1, 0, 99);
        chk_mode("t3s", 2'b10);
        expect_steps("t3b", 13, 0, 0, 2);
        chk_mode("t3b", 2'b00);

        // Back to RUN: count restarts from 0
        btn_mode_raw = 1'b1;
        expect_steps("t5a", 8, 0, 0, 99);
        chk_mode("t5a", 2'b01);
        expect_steps("t5b", 20, 10, 10, 2);

        // Simultaneous mode+step in RUN: only the mode press acts
        btn_mode_raw = 1'b1;
        btn_step_raw = 1'b1;
        expect_steps("t5c", 8, 10, 10, 99);
        chk_mode("t5c", 2'b00);
        expect_steps("t5d", 20, 0, 0, 2);
        chk_mode("t5d", 2'b00);
        btn_mode_raw = 1'b1;
        expect_steps("t5e", 8, 0, 0, 99);
        chk_mode("t5e", 2'b01);
        expect_steps("t5f", 12, 10, 10, 2);

        // Load period 3 at cnt=2
        div_load  = 1'b1;
        div_value = 32'd3;
        expect_steps("t4l", 1, 0, 0, 99);
        div_load  = 1'b0;
        expect_steps("t4a", 12, 4, 4, 99);

        // Back to period 10, then a load exactly at terminal count
        div_load  = 1'b1;
        div_value = 32'd9;
        expect_steps("t4l2", 1, 0, 0, 99);
        div_load  = 1'b0;
        expect_steps("t4b", 9, 0, 0, 99);
        div_load  = 1'b1;
        expect_steps("t4tc", 1, 0, 0, 99);
        div_load  = 1'b0;
        expect_steps("t4c", 10, 10, 10, 99);

        // Asynchronous reset mid-count (phase is 1 beforehand)
        expect_steps("t6p", 10, 10, 10, 99);
        expect_steps("t6a", 5, 0, 0, 99);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_step", 32'(step_en), 32'd0);
        chk("t6_rst_phase", 32'(phase), 32'd0);
        chk_mode("t6_rst", 2'b01);
        phase_exp = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        expect_steps("t6b", 20, 10, 10, 99);
        chk_mode("t6b", 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
